// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP32 width, default pipeline depth and occupancy sizing.
package fpu_pkg;

    localparam int FP32_W     = 32;
    localparam int PIPE_DEPTH = 3;

    typedef logic [FP32_W-1:0] fp32_t;

    // Bits needed to count 0..2*depth items (main + skid slot per stage).
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/fpu_pipe_chain_if.sv
// Valid/ready stream bundle for the FPU pipeline chain, including flush and occupancy.
interface fpu_pipe_chain_if
    import fpu_pkg::*;
#(
    parameter int WIDTH = FP32_W,
    parameter int DEPTH = PIPE_DEPTH
) ();

    localparam int OCC_W = occ_width(DEPTH);

    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [OCC_W-1:0] occupancy;

    // The chain itself.
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    // Whoever drives the chain (upstream producer + downstream consumer).
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/pipe_skid_stage.sv
// One elastic register stage: a main slot feeding the output and a skid slot
// that absorbs the item arriving while the main slot is stalled. in_ready is
// taken straight from a register, so it never depends on out_ready.
module pipe_skid_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    input  logic             i_out_ready
);

    logic             r_main_v;
    logic             r_skid_v;
    logic [WIDTH-1:0] r_main_d;
    logic [WIDTH-1:0] r_skid_d;
    logic             w_acc;
    logic             w_pop;

    assign o_in_ready  = !r_skid_v;
    assign o_out_valid = r_main_v;
    assign o_out_data  = r_main_d;
    assign w_acc       = i_in_valid & !r_skid_v;
    assign w_pop       = r_main_v & i_out_ready;

    // Slot update: refill main from skid first, else from the input; park in skid when stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= '0;
            r_skid_d <= '0;
        end else if (i_flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_main_v || w_pop) begin
            if (r_skid_v) begin
                r_main_v <= 1'b1;
                r_main_d <= r_skid_d;
                r_skid_v <= 1'b0;
            end else begin
                r_main_v <= w_acc;
                if (w_acc) begin
                    r_main_d <= i_in_data;
                end
            end
        end else if (w_acc) begin
            r_skid_v <= 1'b1;
            r_skid_d <= i_in_data;
        end
    end

endmodule

// File: rtl/fpu_pipe_chain.sv
// Elastic pipeline-register chain for the FPU_32 datapath: DEPTH skid stages in
// series, flush fan-out and a registered occupancy counter.
module fpu_pipe_chain
    import fpu_pkg::*;
#(
    parameter int WIDTH = FP32_W,
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_pipe_chain_if.slave       bus
);

    localparam int OCC_W = occ_width(DEPTH);

    // Index k is the link entering stage k; index DEPTH is the chain output.
    logic             w_valid [0:DEPTH];
    logic [WIDTH-1:0] w_data  [0:DEPTH];
    logic             w_ready [0:DEPTH];

    logic [OCC_W-1:0] r_occ;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_valid[0]     = bus.in_valid;
    assign w_data[0]      = bus.in_data;
    assign bus.in_ready   = w_ready[0];
    assign bus.out_valid  = w_valid[DEPTH];
    assign bus.out_data   = w_data[DEPTH];
    assign w_ready[DEPTH] = bus.out_ready;
    assign bus.occupancy  = r_occ;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            pipe_skid_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk         (clk),
                .rst         (rst),
                .i_flush     (bus.flush),
                .i_in_valid  (w_valid[gi]),
                .i_in_data   (w_data[gi]),
                .o_in_ready  (w_ready[gi]),
                .o_out_valid (w_valid[gi+1]),
                .o_out_data  (w_data[gi+1]),
                .i_out_ready (w_ready[gi+1])
            );
        end
    endgenerate

    // Only the chain boundaries change the item count; internal hand-offs do not.
    assign w_in_fire  = bus.in_valid & w_ready[0];
    assign w_out_fire = w_valid[DEPTH] & bus.out_ready;

    // Occupancy counter; flush empties every slot, so the count drops to zero with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (bus.flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_fire) - OCC_W'(w_out_fire);
        end
    end

endmodule

// File: tb/tb_fpu_pipe_chain.sv
// Directed + random bench for fpu_pipe_chain: a 32x3 chain (main) and a 1x1 corner chain.
module tb_fpu_pipe_chain;
    import fpu_pkg::*;

    localparam int DA = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fpu_pipe_chain_if #(.WIDTH(32), .DEPTH(DA)) a_if ();
    fpu_pipe_chain_if #(.WIDTH(1),  .DEPTH(1))  b_if ();

    fpu_pipe_chain #(.WIDTH(32), .DEPTH(DA)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    fpu_pipe_chain #(.WIDTH(1),  .DEPTH(1))  dut_b (.clk(clk), .rst(rst), .bus(b_if));

    always #5 clk = ~clk;

    typedef struct {
        fp32_t d;
        int    c;
    } item_t;

    item_t qa [$];
    logic  qb [$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   a_pops = 0;
    logic a_fire_in = 1'b0;
    logic b_fire_in = 1'b0;
    logic lat_chk = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with this cycle's inputs driven; scores the upcoming posedge.
    task automatic cycle_a();
        item_t it;
        chk("a_occupancy", 64'(a_if.occupancy), 64'(qa.size()));
        if (qa.size() == 0) chk("a_idle_out_valid", 64'(a_if.out_valid), 64'd0);
        a_fire_in = 1'b0;
        if (a_if.flush) begin
            qa.delete();
        end else begin
            if (a_if.out_valid && a_if.out_ready && qa.size() != 0) begin
                it = qa.pop_front();
                chk("a_out_data", 64'(a_if.out_data), 64'(it.d));
                if (lat_chk) chk("a_latency", 64'(cyc - it.c), 64'(DA));
                a_pops++;
            end
            if (a_if.in_valid && a_if.in_ready) begin
                it.d = a_if.in_data;
                it.c = cyc;
                qa.push_back(it);
                a_fire_in = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle_b();
        chk("b_occupancy", 64'(b_if.occupancy), 64'(qb.size()));
        chk("b_in_ready", 64'(b_if.in_ready), 64'(qb.size() < 2));
        if (qb.size() == 0) chk("b_idle_out_valid", 64'(b_if.out_valid), 64'd0);
        b_fire_in = 1'b0;
        if (b_if.out_valid && b_if.out_ready && qb.size() != 0) begin
            chk("b_out_data", 64'(b_if.out_data), 64'(qb[0]));
            void'(qb.pop_front());
        end
        if (b_if.in_valid && b_if.in_ready) begin
            qb.push_back(b_if.in_data);
            b_fire_in = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int    k;
        int    peak;
        int    p0;
        fp32_t stream [3];
        stream[0] = 32'h3F80_0000;
        stream[1] = 32'h4000_0000;
        stream[2] = 32'h4040_0000;

        a_if.flush = 0; a_if.in_valid = 0; a_if.in_data = '0; a_if.out_ready = 0;
        b_if.flush = 0; b_if.in_valid = 0; b_if.in_data = '0; b_if.out_ready = 0;

        // 1: asynchronous reset takes effect before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
        chk("rst_in_ready",  64'(a_if.in_ready),  64'd1);
        chk("rst_occupancy", 64'(a_if.occupancy), 64'd0);
        chk("rst_out_data",  64'(a_if.out_data),  64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 2: back-to-back stream, latency DEPTH, occupancy peaks at 3
        a_if.out_ready = 1'b1;
        lat_chk = 1'b1;
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                a_if.in_valid = 1'b1;
                a_if.in_data  = stream[i];
            end else begin
                a_if.in_valid = 1'b0;
            end
            if (int'(a_if.occupancy) > peak) peak = int'(a_if.occupancy);
            cycle_a();
        end
        lat_chk = 1'b0;
        chk("t2_peak_occupancy", 64'(peak), 64'd3);
        chk("t2_all_out", 64'(a_pops), 64'd3);

        // reset asserted mid-stream drops everything immediately
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1; a_if.in_data = 32'h1111_1111; cycle_a();
        a_if.in_data = 32'h2222_2222; cycle_a();
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 8 && !a_if.out_valid; i++) cycle_a();
        chk("rst_mid_pre_valid", 64'(a_if.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(a_if.out_valid), 64'd0);
        chk("rst_mid_in_ready",  64'(a_if.in_ready),  64'd1);
        chk("rst_mid_occupancy", 64'(a_if.occupancy), 64'd0);
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle_a();

        // 3: backpressure absorbs 2*DEPTH items, then drains on consecutive cycles
        a_if.out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = 32'hA000_0000 + k;
            cycle_a();
            if (a_fire_in) k++;
        end
        a_if.in_valid = 1'b0;
        chk("t3_accepted", 64'(k), 64'd6);
        chk("t3_in_ready_full", 64'(a_if.in_ready), 64'd0);
        chk("t3_occupancy_full", 64'(a_if.occupancy), 64'd6);
        a_if.out_ready = 1'b1;
        p0 = a_pops;
        for (int i = 0; i < 6; i++) cycle_a();
        chk("t3_drain_consecutive", 64'(a_pops - p0), 64'd6);
        cycle_a();

        // 4: random valid/ready against the FIFO model
        a_if.in_valid = 1'b0;
        a_fire_in = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!a_if.in_valid || a_fire_in) begin
                a_if.in_valid = ($urandom_range(0, 3) != 0);
                a_if.in_data  = $urandom();
            end
            a_if.out_ready = ($urandom_range(0, 3) != 0);
            cycle_a();
        end
        a_if.in_valid = 1'b0;
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 20 && qa.size() != 0; i++) cycle_a();
        chk("t4_drained", 64'(qa.size()), 64'd0);
        cycle_a();

        // 5: flush beats simultaneous in/out transfers at occupancy 4
        a_if.out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 10 && k < 4; i++) begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = 32'hB000_0000 + k;
            cycle_a();
            if (a_fire_in) k++;
        end
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 10 && !a_if.out_valid; i++) cycle_a();
        chk("t5_pre_out_valid", 64'(a_if.out_valid), 64'd1);
        chk("t5_pre_in_ready",  64'(a_if.in_ready),  64'd1);
        chk("t5_pre_occupancy", 64'(a_if.occupancy), 64'd4);
        a_if.flush = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.in_data = 32'hDEAD_BEEF;
        a_if.out_ready = 1'b1;
        cycle_a();
        a_if.flush = 1'b0;
        a_if.in_valid = 1'b0;
        chk("t5_post_out_valid", 64'(a_if.out_valid), 64'd0);
        chk("t5_post_occupancy", 64'(a_if.occupancy), 64'd0);
        cycle_a();
        p0 = a_pops;
        a_if.in_valid = 1'b1;
        a_if.in_data = 32'h1234_5678;
        for (int i = 0; i < 5 && !a_fire_in; i++) cycle_a();
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 10 && qa.size() != 0; i++) cycle_a();
        chk("t5_next_item_out", 64'(a_pops - p0), 64'd1);

        // 6: DEPTH=1, WIDTH=1 corner -- capacity 2, in_ready independent of out_ready
        b_if.out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            b_if.in_valid = 1'b1;
            b_if.in_data  = k[0];
            cycle_b();
            if (b_fire_in) k++;
        end
        b_if.in_valid = 1'b0;
        chk("t6_capacity", 64'(k), 64'd2);
        b_fire_in = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!b_if.in_valid || b_fire_in) begin
                b_if.in_valid = ($urandom_range(0, 3) != 0);
                b_if.in_data  = $urandom_range(0, 1);
            end
            b_if.out_ready = ~i[0];
            #1;
            chk("t6_in_ready_a", 64'(b_if.in_ready), 64'(qb.size() < 2));
            b_if.out_ready = i[0];
            #1;
            chk("t6_in_ready_b", 64'(b_if.in_ready), 64'(qb.size() < 2));
            b_if.out_ready = ~i[0];
            cycle_b();
        end
        b_if.in_valid = 1'b0;
        b_if.out_ready = 1'b1;
        for (int i = 0; i < 5 && qb.size() != 0; i++) cycle_b();
        chk("t6_drained", 64'(qb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
